// File: rtl/mem_miss_ctrl_if.sv
// MMU-side request/response bus of the memory-stage miss controller.
// The controller drives the request half through the master modport.
interface mem_miss_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 512
);
    logic              mmu_req;
    logic              mmu_we;
    logic [ADDR_W-1:0] mmu_addr;
    logic [LINE_W-1:0] mmu_wdata;
    logic              mmu_ack;
    logic              mmu_rdata_valid;
    logic [LINE_W-1:0] mmu_rdata;

    modport master (
        output mmu_req, mmu_we, mmu_addr, mmu_wdata,
        input  mmu_ack, mmu_rdata_valid, mmu_rdata
    );

    modport slave (
        input  mmu_req, mmu_we, mmu_addr, mmu_wdata,
        output mmu_ack, mmu_rdata_valid, mmu_rdata
    );
endinterface

// File: rtl/mem_miss_ctrl.sv
// Memory-stage miss controller: dirty-victim writeback, line fill over the MMU bus, replay.
// Defining MEM_MISS_PERF_EN adds saturating hit/miss/writeback/stall-cycle counters.
module mem_miss_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int LINE_W  = 512,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              halt,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              cache_hit,
    input  logic              cache_miss,
    input  logic              cache_dirty,
    input  logic [ADDR_W-1:0] cache_victim_addr,
    input  logic [LINE_W-1:0] cache_blk_out,
    mem_miss_ctrl_if.master   mmu,
    output logic              stall,
    output logic              load_line,
    output logic [LINE_W-1:0] blk_in,
    output logic              timeout_err
`ifdef MEM_MISS_PERF_EN
    ,
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
    output logic [31:0]       wb_cnt,
    output logic [31:0]       stall_cycles
`endif
);
    // state  | meaning
    // IDLE   | accept requests; a miss starts a transaction
    // WB     | dirty victim line offered to the MMU until ack
    // FILL   | fill request offered to the MMU until ack
    // FWAIT  | fill acked, waiting for line data
    // LOAD   | load_line pulse, blk_in holds the fetched line
    // REPLAY | last stall cycle before the access is re-presented
    typedef enum logic [2:0] {S_IDLE, S_WB, S_FILL, S_FWAIT, S_LOAD, S_REPLAY} state_t;

    localparam int OFF     = $clog2(LINE_W / 8);
    localparam int CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFF], {OFF{1'b0}}};
    endfunction

    state_t            state;
    logic [ADDR_W-1:0] miss_addr;
    logic [CNT_W-1:0]  wd_cnt;
    logic              stall_q;
    logic              req;
    logic              miss_start;
    logic              wd_fire;
    logic              unused_ok;

    assign req        = (mem_read | mem_write) & ~halt;
    assign miss_start = (state == S_IDLE) & req & cache_miss;
    // The miss cycle itself must stall before the FSM has registered anything.
    assign stall      = rst & (stall_q | miss_start);
    assign wd_fire    = (TIMEOUT > 0) && (wd_cnt == CNT_W'(TO_LAST));
    assign unused_ok  = ^{req_addr[OFF-1:0], cache_victim_addr[OFF-1:0], cache_hit};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            miss_addr     <= '0;
            wd_cnt        <= '0;
            stall_q       <= 1'b0;
            mmu.mmu_req   <= 1'b0;
            mmu.mmu_we    <= 1'b0;
            mmu.mmu_addr  <= '0;
            mmu.mmu_wdata <= '0;
            load_line     <= 1'b0;
            blk_in        <= '0;
            timeout_err   <= 1'b0;
        end else begin
            load_line <= 1'b0;
            wd_cnt    <= '0;
            case (state)
                S_IDLE: begin
                    if (miss_start) begin
                        miss_addr   <= line_addr(req_addr);
                        stall_q     <= 1'b1;
                        mmu.mmu_req <= 1'b1;
                        if (cache_dirty) begin
                            state         <= S_WB;
                            mmu.mmu_we    <= 1'b1;
                            mmu.mmu_addr  <= line_addr(cache_victim_addr);
                            mmu.mmu_wdata <= cache_blk_out;
                        end else begin
                            state         <= S_FILL;
                            mmu.mmu_we    <= 1'b0;
                            mmu.mmu_addr  <= line_addr(req_addr);
                            mmu.mmu_wdata <= '0;
                        end
                    end
                end
                S_WB: begin
                    if (mmu.mmu_ack) begin
                        state         <= S_FILL;
                        mmu.mmu_we    <= 1'b0;
                        mmu.mmu_addr  <= miss_addr;
                        mmu.mmu_wdata <= '0;
                    end else if (wd_fire) begin
                        state         <= S_IDLE;
                        stall_q       <= 1'b0;
                        timeout_err   <= 1'b1;
                        mmu.mmu_req   <= 1'b0;
                        mmu.mmu_we    <= 1'b0;
                        mmu.mmu_addr  <= '0;
                        mmu.mmu_wdata <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_FILL: begin
                    if (mmu.mmu_ack) begin
                        mmu.mmu_req  <= 1'b0;
                        mmu.mmu_addr <= '0;
                        if (mmu.mmu_rdata_valid) begin
                            state     <= S_LOAD;
                            blk_in    <= mmu.mmu_rdata;
                            load_line <= 1'b1;
                        end else begin
                            state <= S_FWAIT;
                        end
                    end else if (wd_fire) begin
                        state        <= S_IDLE;
                        stall_q      <= 1'b0;
                        timeout_err  <= 1'b1;
                        mmu.mmu_req  <= 1'b0;
                        mmu.mmu_addr <= '0;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_FWAIT: begin
                    if (mmu.mmu_rdata_valid) begin
                        state     <= S_LOAD;
                        blk_in    <= mmu.mmu_rdata;
                        load_line <= 1'b1;
                    end else if (wd_fire) begin
                        state       <= S_IDLE;
                        stall_q     <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + CNT_W'(1);
                    end
                end
                S_LOAD: begin
                    state <= S_REPLAY;
                end
                S_REPLAY: begin
                    state   <= S_IDLE;
                    stall_q <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MEM_MISS_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_cnt      <= '0;
            miss_cnt     <= '0;
            wb_cnt       <= '0;
            stall_cycles <= '0;
        end else begin
            if (state == S_IDLE && req && cache_hit && !cache_miss && hit_cnt != '1)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start && miss_cnt != '1)
                miss_cnt <= miss_cnt + 32'd1;
            if (state == S_WB && mmu.mmu_ack && wb_cnt != '1)
                wb_cnt <= wb_cnt + 32'd1;
            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mem_miss_ctrl.sv
// Directed bench for mem_miss_ctrl: each transaction's expected outputs are derived from its
// MMU response schedule by cycle arithmetic, checked every cycle by one compare process.
module tb_mem_miss_ctrl;
    localparam int ADDR_W  = 32;
    localparam int LINE_W  = 512;
    localparam int TIMEOUT = 16;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic              mem_read, mem_write, halt, cache_hit, cache_miss, cache_dirty;
    logic [ADDR_W-1:0] req_addr, cache_victim_addr;
    logic [LINE_W-1:0] cache_blk_out, blk_in;
    logic              stall, load_line, timeout_err;
`ifdef MEM_MISS_PERF_EN
    logic [31:0] hit_cnt, miss_cnt, wb_cnt, stall_cycles;
`endif

    mem_miss_ctrl_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) mmu_bus ();

    mem_miss_ctrl #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .halt              (halt),
        .req_addr          (req_addr),
        .cache_hit         (cache_hit),
        .cache_miss        (cache_miss),
        .cache_dirty       (cache_dirty),
        .cache_victim_addr (cache_victim_addr),
        .cache_blk_out     (cache_blk_out),
        .mmu               (mmu_bus),
        .stall             (stall),
        .load_line         (load_line),
        .blk_in            (blk_in),
        .timeout_err       (timeout_err)
`ifdef MEM_MISS_PERF_EN
        ,
        .hit_cnt           (hit_cnt),
        .miss_cnt          (miss_cnt),
        .wb_cnt            (wb_cnt),
        .stall_cycles      (stall_cycles)
`endif
    );

    int checks = 0;
    int errors = 0;

    // expectations for the current cycle
    bit                chk_en = 0;
    logic              e_stall, e_req, e_we, e_load, e_terr, e_blk_chk;
    logic [ADDR_W-1:0] e_addr;
    logic [LINE_W-1:0] e_wdata, e_blk;
    bit                m_terr = 0;

    // observations used by the literal expectations
    int                stall_seen, load_seen;
    logic [ADDR_W-1:0] wb_addr_seen, fill_addr_seen;

    task automatic check(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", stall, e_stall);
            check("mmu_req", mmu_bus.mmu_req, e_req);
            check("mmu_we", mmu_bus.mmu_we, e_we);
            check("mmu_addr", mmu_bus.mmu_addr, e_addr);
            check("mmu_wdata", mmu_bus.mmu_wdata, e_wdata);
            check("load_line", load_line, e_load);
            check("timeout_err", timeout_err, e_terr);
            if (e_blk_chk) check("blk_in", blk_in, e_blk);
            if (stall) stall_seen++;
            if (load_line) load_seen++;
            if (mmu_bus.mmu_req && mmu_bus.mmu_we) wb_addr_seen = mmu_bus.mmu_addr;
            if (mmu_bus.mmu_req && !mmu_bus.mmu_we) fill_addr_seen = mmu_bus.mmu_addr;
        end
    end

    task automatic set_quiet();
        mem_read = 0; mem_write = 0; halt = 0; cache_hit = 0; cache_miss = 0; cache_dirty = 0;
        req_addr = '0; cache_victim_addr = '0; cache_blk_out = '0;
        mmu_bus.mmu_ack = 0; mmu_bus.mmu_rdata_valid = 0; mmu_bus.mmu_rdata = '0;
        e_stall = 0; e_req = 0; e_we = 0; e_addr = '0; e_wdata = '0;
        e_load = 0; e_blk_chk = 0; e_blk = '0; e_terr = m_terr;
    endtask

    task automatic clear_seen();
        stall_seen = 0; load_seen = 0; wb_addr_seen = '0; fill_addr_seen = '0;
    endtask

    // Cycles with no transaction: any request present must not start one.
    task automatic idle_cycles(input int n, input bit rd, input bit hit, input bit miss,
                               input bit hlt, input logic [ADDR_W-1:0] addr, input bit rvalid);
        clear_seen();
        for (int k = 0; k < n; k++) begin
            set_quiet();
            mem_read = rd; cache_hit = hit; cache_miss = miss; halt = hlt; req_addr = addr;
            mmu_bus.mmu_rdata_valid = rvalid; mmu_bus.mmu_rdata = rnd_line();
            e_blk_chk = rvalid; e_blk = '0;
            @(posedge clk); #1;
        end
        set_quiet();
    endtask

    // wa/fa: wait cycles before the WB/FILL ack; dd: FWAIT cycles (0 = data with the fill ack);
    // to: fill is never acked; hmid: halt raised during the transaction; stop_at: abandon at cycle.
    task automatic run_txn(input bit wr, input bit dirty, input logic [ADDR_W-1:0] addr,
                           input logic [ADDR_W-1:0] vaddr, input int wa, input int fa, input int dd,
                           input bit to, input bit hmid, input int stop_at);
        logic [LINE_W-1:0] vdata, fdata, junk;
        int lw, f0, fend, ld, last, kdat;
        bit busy;
        vdata = rnd_line(); fdata = rnd_line(); junk = rnd_line();
        lw   = dirty ? wa + 1 : 0;
        f0   = 1 + lw;
        fend = to ? f0 + TIMEOUT : f0 + fa + 1;
        ld   = fend + dd;
        kdat = (dd == 0) ? f0 + fa : fend + dd - 1;
        last = to ? fend + 2 : ld + 3;
        clear_seen();
        for (int k = 0; k < last; k++) begin
            if (k == stop_at) return;
            set_quiet();
            busy = to ? (k < fend) : (k < ld + 2);
            if (busy || (!to && k == ld + 2)) begin
                mem_read = !wr; mem_write = wr; req_addr = addr;
                cache_miss = busy && (to || k <= ld);
                cache_hit  = !cache_miss;
            end
            halt = hmid && busy && k >= 1;
            cache_dirty = dirty; cache_victim_addr = vaddr; cache_blk_out = vdata;
            mmu_bus.mmu_ack = !to && ((dirty && k == wa + 1) || k == f0 + fa);
            mmu_bus.mmu_rdata_valid = !to && (k == kdat || (dirty && k >= 1 && k < wa + 1) || k == ld + 1);
            mmu_bus.mmu_rdata = (!to && k == kdat) ? fdata : junk;
            e_stall   = busy;
            e_req     = (k >= 1) && (k < fend);
            e_we      = dirty && (k >= 1) && (k < f0);
            e_addr    = e_we ? (vaddr & LINE_MASK) : (e_req ? (addr & LINE_MASK) : '0);
            e_wdata   = e_we ? vdata : '0;
            e_load    = !to && (k == ld);
            e_blk_chk = e_load;
            e_blk     = fdata;
            e_terr    = m_terr || (to && k >= fend);
            @(posedge clk); #1;
        end
        if (to) m_terr = 1;
        set_quiet();
    endtask

    initial begin
        set_quiet();
        @(posedge clk); @(posedge clk); #1;
        check("reset stall", stall, 1'b0);
        check("reset mmu_req", mmu_bus.mmu_req, 1'b0);
        check("reset load_line", load_line, 1'b0);
        check("reset blk_in", blk_in, '0);
        check("reset timeout_err", timeout_err, 1'b0);
        rst = 1; chk_en = 1;
        @(posedge clk); #1;

        idle_cycles(4, 1, 1, 0, 0, 32'h1000, 0);
        check("hit stall cycles", stall_seen, 0);

        run_txn(0, 0, 32'h1234, '0, 0, 2, 3, 0, 0, -1);
        check("clean stall cycles", stall_seen, 9);
        check("clean load pulses", load_seen, 1);
        check("clean fill addr", fill_addr_seen, 32'h1200);

        run_txn(1, 1, 32'h0088, 32'h8040, 1, 1, 2, 0, 0, -1);
        check("dirty wb addr", wb_addr_seen, 32'h8040);
        check("dirty fill addr", fill_addr_seen, 32'h0080);
        check("dirty stall cycles", stall_seen, 9);

        run_txn(0, 0, 32'h40c4, '0, 0, 0, 0, 0, 0, -1);
        check("same-cycle stall cycles", stall_seen, 4);
        check("same-cycle load pulses", load_seen, 1);

        run_txn(0, 0, 32'h7ffc, '0, 0, 2, 0, 0, 0, -1);
        check("late same-cycle stall cycles", stall_seen, 6);

        idle_cycles(3, 1, 0, 1, 1, 32'h5000, 0);
        check("halted miss stall cycles", stall_seen, 0);

        run_txn(0, 0, 32'h5040, '0, 0, 1, 1, 0, 1, -1);
        check("halt-mid stall cycles", stall_seen, 6);
        run_txn(1, 1, 32'h9abc, 32'h13c0, 0, 0, 1, 0, 0, -1);
        check("back-to-back dirty stall cycles", stall_seen, 6);

        run_txn(0, 0, 32'h2000, '0, 0, 0, 0, 1, 0, -1);
        check("timeout stall cycles", stall_seen, 17);
        check("timeout load pulses", load_seen, 0);
        idle_cycles(3, 1, 1, 0, 0, 32'h1000, 0);
        check("sticky timeout_err", timeout_err, 1'b1);

        run_txn(0, 0, 32'h3000, '0, 0, 0, 10, 0, 0, 4);
        #2;
        m_terr = 0;
        set_quiet();
        mem_read = 1; cache_miss = 1; req_addr = 32'h3000;
        rst = 0;
        #1;
        check("async reset stall", stall, 1'b0);
        check("async reset mmu_req", mmu_bus.mmu_req, 1'b0);
        check("async reset mmu_addr", mmu_bus.mmu_addr, '0);
        check("async reset load_line", load_line, 1'b0);
        check("async reset blk_in", blk_in, '0);
        check("async reset timeout_err", timeout_err, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        set_quiet();
        rst = 1;
        idle_cycles(3, 0, 0, 0, 0, '0, 1);
        check("late data load pulses", load_seen, 0);
        check("late data blk_in", blk_in, '0);

        chk_en = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit");
    end
endmodule

// File: doc/mem_miss_ctrl.md
Name: mem_miss_ctrl

Overview:
Parametrised miss-handling controller for the memory stage, sitting between the pipeline's load/store request, the data cache, and the MMU.
- On a data-cache miss it stalls the pipeline and writes back a dirty victim line.
- It then fetches the missing line from the MMU, loads it into the cache, and replays the access.
- It replaces the stateless cache-to-MMU wiring with an explicit handshake, a line buffer and a watchdog timeout.

Parameters:
ADDR_W, 32, byte address width
LINE_W, 512, cache line width in bits; power of 2, >= 64
TIMEOUT, 1024, max cycles waiting on MMU per transaction; 0 disables watchdog

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
mem_read  in  1  pipeline load request
mem_write  in  1  pipeline store request
halt  in  1  suppresses new requests while high
req_addr  in  ADDR_W  access byte address (ALU result)
cache_hit  in  1  cache lookup hit, same cycle as request
cache_miss  in  1  cache lookup miss, same cycle as request
cache_dirty  in  1  victim line valid and dirty, qualified by cache_miss
cache_victim_addr  in  ADDR_W  line-aligned victim address
cache_blk_out  in  LINE_W  victim line data
mmu_ack  in  1  MMU accepted current request
mmu_rdata_valid  in  1  fill data valid
mmu_rdata  in  LINE_W  fill line data
stall  out  1  freeze pipeline
mmu_req  out  1  MMU request valid
mmu_we  out  1  1 = writeback, 0 = fill
mmu_addr  out  ADDR_W  line-aligned MMU address
mmu_wdata  out  LINE_W  writeback line
load_line  out  1  one-cycle pulse: write blk_in into cache
blk_in  out  LINE_W  fill line to cache
timeout_err  out  1  sticky watchdog error

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0. Line buffers and counters 0.
- Request valid: req = (mem_read | mem_write) & ~halt.
- Line alignment: low log2(LINE_W/8) bits of address forced to 0 (6 bits at default).
- IDLE:
  - req & cache_hit: no action, stall=0.
  - req & cache_miss: latch aligned req_addr.
    - If cache_dirty: latch victim addr/data, go to WB.
    - Else: go to FILL.
  - stall is combinationally high in the miss cycle and stays high until REPLAY exits.
- WB:
  - mmu_req=1, mmu_we=1, mmu_addr=victim addr, mmu_wdata=victim line.
  - Outputs held stable until mmu_ack. On mmu_ack go to FILL.
- FILL:
  - mmu_req=1, mmu_we=0, mmu_addr=miss addr.
  - mmu_ack: go to FWAIT.
  - mmu_ack & mmu_rdata_valid in the same cycle: capture data and go directly to LOAD.
- FWAIT:
  - mmu_req=0. On mmu_rdata_valid capture mmu_rdata, go to LOAD.
  - mmu_rdata_valid is ignored in every other state.
- LOAD: load_line=1 for exactly one cycle, blk_in=captured line, go to REPLAY.
- REPLAY: stall=1 for one cycle, then IDLE. The pipeline re-presents the access, which must now hit.
- Miss latency:
  - Clean: 1 + FILL cycles + FWAIT cycles + 2.
  - Clean with ack and data in the same cycle: 4 cycles of stall minimum.
- halt:
  - Blocks new misses in IDLE.
  - A transaction already in progress always completes.
- Watchdog (TIMEOUT>0):
  - Counter clears on each state entry and increments in WB/FILL/FWAIT.
  - On reaching TIMEOUT: set timeout_err (sticky until reset), drop mmu_req, go to IDLE with stall=0. No load_line.
- mmu_addr and mmu_wdata are 0 whenever mmu_req=0.

Optional Feature:
MEM_MISS_PERF_EN
- Defined: adds outputs hit_cnt, miss_cnt, wb_cnt (32 bits each) and stall_cycles (32 bits).
  - hit_cnt and miss_cnt count IDLE-state req events.
  - wb_cnt counts WB mmu_ack.
  - stall_cycles counts cycles with stall=1.
  - All saturate at all-ones and reset to 0.
- Undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- Hit: mem_read=1, cache_hit=1, req_addr=0x1000 -> stall=0, mmu_req never asserted.
- Clean miss: mem_read, cache_miss=1, cache_dirty=0, req_addr=0x1234.
  - MMU acks 2 cycles later; data 3 cycles after ack.
  - Expect mmu_addr=0x1200, mmu_we=0, a single load_line pulse with blk_in = mmu_rdata.
  - stall high continuously, low after REPLAY.
- Dirty miss: mem_write, cache_dirty=1, victim addr=0x8040, req_addr=0x0088.
  - Expect WB first: mmu_we=1, mmu_addr=0x8040, mmu_wdata = victim line.
  - Then fill: mmu_addr=0x0080.
- Same-cycle ack+data in FILL -> LOAD on the next cycle, no FWAIT cycle, total stall 4 cycles.
- Timeout: TIMEOUT=16, miss, never ack -> mmu_req drops after 16 cycles, timeout_err=1 and stays 1, stall=0, no load_line.
- Reset mid-FWAIT: drive rst low asynchronously -> all outputs 0 immediately. After release, state is IDLE and a late mmu_rdata_valid is ignored.
